// File: rtl/systolic_feeder.sv
// Operand staging for the N_SIZE x N_SIZE systolic array: buffers A and B, streams
// one aligned A column / B row per cycle on start, then waits for N_SIZE result rows.
module systolic_feeder #(
  parameter int N_SIZE    = 5,
  parameter int DATAWIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      wr_en,
  input  logic                                      wr_sel,
  input  logic [$clog2(N_SIZE)-1:0]                 wr_row,
  input  logic [$clog2(N_SIZE)-1:0]                 wr_col,
  input  logic signed [DATAWIDTH-1:0]               wr_data,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic                                      arr_valid,
  output logic                                      feed_valid,
  output logic signed [N_SIZE-1:0][DATAWIDTH-1:0]   matrix_a_out,
  output logic signed [N_SIZE-1:0][DATAWIDTH-1:0]   matrix_b_out,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      wr_ignored
);
  localparam int IW = $clog2(N_SIZE);
  localparam int CW = $clog2(N_SIZE + 1);
  localparam logic [IW:0] NLIM = (IW+1)'(N_SIZE);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] beat_q, beat_d, row_q, row_d;
  logic feed_valid_q, feed_valid_d, done_q, done_d, wr_ign_q, wr_ign_d;
  logic [N_SIZE-1:0][DATAWIDTH-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] a_buf_q, b_buf_q;

  logic          start_go, oob, wr_go, load;
  logic [IW-1:0] beat_sel;

  assign start_go = start && !abort;
  assign oob      = ({1'b0, wr_row} >= NLIM) || ({1'b0, wr_col} >= NLIM);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    row_d        = row_q;
    feed_valid_d = 1'b0;
    done_d       = 1'b0;
    wr_ign_d     = 1'b0;
    wr_go        = 1'b0;
    load         = 1'b0;
    beat_sel     = '0;
    a_out_d      = '0;
    b_out_d      = '0;
    case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d      = STREAM;
          load         = 1'b1;
          feed_valid_d = 1'b1;
          beat_d       = CW'(1);
        end
        // start takes priority over a same-cycle write
        if (wr_en) begin
          if (start_go || oob) wr_ign_d = 1'b1;
          else                 wr_go    = 1'b1;
        end
      end
      STREAM: begin
        wr_ign_d = wr_en;
        if (abort) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (beat_q == CW'(N_SIZE)) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          load     = 1'b1;
          beat_sel = beat_q[IW-1:0];
          beat_d   = beat_q + CW'(1);
        end
      end
      DRAIN: begin
        wr_ign_d = wr_en;
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
        end else if (arr_valid) begin
          if (row_q == CW'(N_SIZE - 1)) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      for (int i = 0; i < N_SIZE; i++) begin
        a_out_d[i] = a_buf_q[i][beat_sel];
        b_out_d[i] = b_buf_q[beat_sel][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      row_q        <= '0;
      feed_valid_q <= 1'b0;
      done_q       <= 1'b0;
      wr_ign_q     <= 1'b0;
      a_out_q      <= '0;
      b_out_q      <= '0;
      a_buf_q      <= '0;
      b_buf_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      row_q        <= row_d;
      feed_valid_q <= feed_valid_d;
      done_q       <= done_d;
      wr_ign_q     <= wr_ign_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
      if (wr_go) begin
        if (wr_sel) b_buf_q[wr_row][wr_col] <= wr_data;
        else        a_buf_q[wr_row][wr_col] <= wr_data;
      end
    end
  end

  assign feed_valid   = feed_valid_q;
  assign matrix_a_out = a_out_q;
  assign matrix_b_out = b_out_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign wr_ignored   = wr_ign_q;
endmodule
